// File: rtl/tick_bcd_display.sv
// Counts rising edges of an asynchronous slow square wave in BCD and shows the
// four-digit value on a multiplexed common-anode seven-segment display.
module tick_bcd_display #(
   parameter int unsigned SCAN_BITS = 16,
   parameter bit          BLANK_LZ  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        slow_clk,
   input  logic        en,
   input  logic        clr,
   output logic [15:0] count,
   output logic        tick,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int unsigned DIGITS    = 4;
   localparam int unsigned NIB_W     = 4;
   localparam int unsigned SEG_W     = 7;
   localparam int unsigned SEL_W     = 2;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;

   logic                    s1, s2, s3;
   logic [SCAN_BITS-1:0]    scan;
   logic [SEL_W-1:0]        sel;
   logic [NIB_W-1:0]        digit;
   logic                    blank;
   logic [DIGITS-1:0]       an_nxt;
   logic [SEG_W-1:0]        seg_nxt;

   // Increment a 4-digit BCD value; 9999 wraps to 0000.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[NIB_W*i +: NIB_W] == 4'd9) begin
               r[NIB_W*i +: NIB_W] = 4'd0;
            end else begin
               r[NIB_W*i +: NIB_W] = v[NIB_W*i +: NIB_W] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Two-flop synchronizer plus edge history flop for slow_clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= slow_clk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign tick = s2 & ~s3;

   // BCD counter; clear takes priority over an enabled tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 16'h0000;
      end else if (clr) begin
         count <= 16'h0000;
      end else if (tick && en) begin
         count <= bcd_inc(count);
      end
   end

   // Free-running scan counter; its top two bits pick the active digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan <= '0;
      end else begin
         scan <= scan + SCAN_BITS'(1);
      end
   end

   assign sel = scan[SCAN_BITS-1 -: SEL_W];

   // Select digit, decide leading-zero blanking and decode to segments.
   always_comb begin
      an_nxt  = 4'b1110;
      digit   = count[3:0];
      blank   = 1'b0;
      seg_nxt = SEG_BLANK;
      case (sel)
         2'd0: begin
            an_nxt = 4'b1110;
            digit  = count[3:0];
         end
         2'd1: begin
            an_nxt = 4'b1101;
            digit  = count[7:4];
            blank  = BLANK_LZ && (count[15:4] == 12'h000);
         end
         2'd2: begin
            an_nxt = 4'b1011;
            digit  = count[11:8];
            blank  = BLANK_LZ && (count[15:8] == 8'h00);
         end
         default: begin
            an_nxt = 4'b0111;
            digit  = count[15:12];
            blank  = BLANK_LZ && (count[15:12] == 4'h0);
         end
      endcase
      case (digit)
         4'd0:    seg_nxt = SEG_ZERO;
         4'd1:    seg_nxt = 7'b1111001;
         4'd2:    seg_nxt = 7'b0100100;
         4'd3:    seg_nxt = 7'b0110000;
         4'd4:    seg_nxt = 7'b0011001;
         4'd5:    seg_nxt = 7'b0010010;
         4'd6:    seg_nxt = 7'b0000010;
         4'd7:    seg_nxt = 7'b1111000;
         4'd8:    seg_nxt = 7'b0000000;
         4'd9:    seg_nxt = 7'b0010000;
         default: seg_nxt = SEG_BLANK;
      endcase
      if (blank) begin
         seg_nxt = SEG_BLANK;
      end
   end

   // Anode and segment registers update together so digits never ghost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'b1110;
         seg <= SEG_ZERO;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_tick_bcd_display.sv
// Bench for tick_bcd_display: random slow_clk/en/clr stimulus against an
// integer-valued reference model, plus directed checks on carry, priority,
// blanking and asynchronous reset.
module tb_tick_bcd_display;

   localparam int unsigned SB    = 4;
   localparam int          DEPTH = 1 << SB;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        slow_clk;
   logic        en;
   logic        clr;
   logic [15:0] count_b, count_n;
   logic        tick_b, tick_n;
   logic [3:0]  an_b, an_n;
   logic [6:0]  seg_b, seg_n;

   int total = 0;
   int bad   = 0;

   tick_bcd_display #(.SCAN_BITS(SB), .BLANK_LZ(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .en(en), .clr(clr),
      .count(count_b), .tick(tick_b), .an(an_b), .seg(seg_b));

   tick_bcd_display #(.SCAN_BITS(SB), .BLANK_LZ(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .en(en), .clr(clr),
      .count(count_n), .tick(tick_n), .an(an_n), .seg(seg_n));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Value kept as a plain integer 0..9999; slow_clk history is a sample
   // shift list where index 0 is the newest sample.
   int         m_val;
   int         m_cyc;
   logic [2:0] hist;
   logic [3:0] m_an;
   logic [6:0] m_seg_b, m_seg_n;
   logic       m_tick;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] shape(input int d);
      logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};
      return t[d];
   endfunction

   function automatic logic [6:0] show(input int v, input int k, input bit blz);
      if (blz && k > 0 && v < pow10(k)) return 7'b1111111;
      return shape((v / pow10(k)) % 10);
   endfunction

   assign m_tick = hist[1] & ~hist[2];

   always @(posedge clk or negedge rst_n) begin
      int k;
      if (!rst_n) begin
         m_val   = 0;
         m_cyc   = 0;
         hist    = 3'b000;
         m_an    = 4'b1110;
         m_seg_b = 7'b1000000;
         m_seg_n = 7'b1000000;
      end else begin
         k       = m_cyc / (DEPTH / 4);
         m_an    = ~(4'(1) << k);
         m_seg_b = show(m_val, k, 1'b1);
         m_seg_n = show(m_val, k, 1'b0);
         if (clr) m_val = 0;
         else if (en && m_tick) m_val = (m_val + 1) % 10000;
         m_cyc = (m_cyc + 1) % DEPTH;
         hist  = {hist[1:0], slow_clk};
      end
   end

   // Continuous per-cycle comparison against the model.
   always @(negedge clk) begin
      check("tick",   32'(tick_b),  32'(m_tick));
      check("tick_n", 32'(tick_n),  32'(m_tick));
      check("count",  32'(count_b), 32'(to_bcd(m_val)));
      check("count_n",32'(count_n), 32'(to_bcd(m_val)));
      check("an",     32'(an_b),    32'(m_an));
      check("an_n",   32'(an_n),    32'(m_an));
      check("seg_blz",32'(seg_b),   32'(m_seg_b));
      check("seg_all",32'(seg_n),   32'(m_seg_n));
   end

   // ---------------- stimulus ----------------
   task automatic pulse(input int hi, input int lo);
      slow_clk = 1'b1;
      repeat (hi) @(negedge clk);
      slow_clk = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulse($urandom_range(2, 3), $urandom_range(2, 3));
   endtask

   task automatic clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic reset_vals(input string tag);
      check({tag, "_count"}, 32'(count_b), 32'h0000);
      check({tag, "_tick"},  32'(tick_b),  32'h0);
      check({tag, "_an"},    32'(an_b),    32'hE);
      check({tag, "_seg"},   32'(seg_b),   32'h40);
      check({tag, "_seg_n"}, 32'(seg_n),   32'h40);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_n    = 1'b0;
      slow_clk = 1'b0;
      en       = 1'b1;
      clr      = 1'b0;
      // Reset held while slow_clk toggles.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         slow_clk = ~slow_clk;
      end
      slow_clk = 1'b1;
      @(negedge clk);
      reset_vals("rst");
      // Release with slow_clk already high yields one tick.
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("release_tick", 32'(count_b), 32'h0001);
      slow_clk = 1'b0;
      repeat (3) @(negedge clk);

      // Long high pulse: one tick only.
      pulse(50, 10);
      check("long_pulse", 32'(count_b), 32'h0002);

      // Units carry.
      clear();
      ticks(9);
      check("nine", 32'(count_b), 32'h0009);
      ticks(1);
      check("carry", 32'(count_b), 32'h0010);

      // clr beats a simultaneous enabled tick.
      clear();
      ticks(42);
      check("at42", 32'(count_b), 32'h0042);
      slow_clk = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = tick_b;
      end
      check("tick_seen", 32'(seen), 32'h1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_prio", 32'(count_b), 32'h0000);
      slow_clk = 1'b0;
      repeat (3) @(negedge clk);

      // Disabled counting holds the value.
      ticks(3);
      en = 1'b0;
      ticks(5);
      check("en_hold", 32'(count_b), 32'h0003);
      en = 1'b1;

      // Scan and blanking at 0305.
      clear();
      ticks(305);
      check("at305", 32'(count_b), 32'h0305);
      repeat (40) @(negedge clk);

      // Full-range wrap.
      clear();
      for (int i = 0; i < 9999; i++) pulse(2, 2);
      check("at9999", 32'(count_b), 32'h9999);
      ticks(1);
      check("wrap", 32'(count_b), 32'h0000);

      // Asynchronous reset between clock edges.
      ticks(123);
      check("at123", 32'(count_b), 32'h0123);
      slow_clk = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 reset_vals("async");
      #1 rst_n = 1'b1;
      slow_clk = 1'b0;
      repeat (4) @(negedge clk);
      check("edge_dropped", 32'(count_b), 32'h0000);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 2) == 0) slow_clk = ~slow_clk;
         en  = ($urandom_range(0, 7) != 0);
         clr = ($urandom_range(0, 79) == 0);
      end
      clr = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
